// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Divide is radix-2 restoring. Multiply is shift-add, or a single-cycle
// combinational multiply when MULDIV_FAST_MUL_EN is defined.
// Results are held in DONE until the consumer takes them (valid/ready).
module muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           alu_operation,
    input  logic [XLEN-1:0]      operand_a,
    input  logic [XLEN-1:0]      operand_b,
    input  logic [TAG_WIDTH-1:0] rd_in,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [XLEN-1:0]      result,
    output logic [TAG_WIDTH-1:0] rd_out,
    output logic                 busy
);

    // ALU operation codes shared with decode (isa.svh)
    localparam logic [7:0] ALU_OPERATIONS_MUL    = 8'h30;
    localparam logic [7:0] ALU_OPERATIONS_MULH   = 8'h31;
    localparam logic [7:0] ALU_OPERATIONS_MULHSU = 8'h32;
    localparam logic [7:0] ALU_OPERATIONS_MULHU  = 8'h33;
    localparam logic [7:0] ALU_OPERATIONS_DIV    = 8'h34;
    localparam logic [7:0] ALU_OPERATIONS_DIVU   = 8'h35;
    localparam logic [7:0] ALU_OPERATIONS_REM    = 8'h36;
    localparam logic [7:0] ALU_OPERATIONS_REMU   = 8'h37;

    localparam int            CW        = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;
    typedef enum logic [1:0] {SEL_LO, SEL_HI, SEL_QUO, SEL_REM} sel_e;

    state_e                 r_state;
    state_e                 w_state_next;
    sel_e                   r_sel;
    logic                   r_neg;
    logic [CW-1:0]          r_counter;
    logic [XLEN-1:0]        r_hi;
    logic [XLEN-1:0]        r_lo;
    logic [XLEN-1:0]        r_b;
    logic [XLEN-1:0]        r_result;
    logic [TAG_WIDTH-1:0]   r_rd;

    logic                   w_is_m;
    logic                   w_a_signed;
    logic                   w_b_signed;
    sel_e                   w_sel;
    logic                   w_is_mul;
    logic                   w_is_div;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [XLEN-1:0]        w_a_mag;
    logic [XLEN-1:0]        w_b_mag;
    logic                   w_res_neg;
    logic                   w_div_zero;
    logic                   w_overflow;
    logic                   w_fast;
    logic                   w_special;
    logic [XLEN-1:0]        w_special_result;
    logic                   w_accept;
    logic [XLEN:0]          w_sum;
    logic [XLEN:0]          w_shift;
    logic [XLEN:0]          w_diff;
    logic [2*XLEN-1:0]      w_prod_fix;
    logic [XLEN-1:0]        w_quo_fix;
    logic [XLEN-1:0]        w_rem_fix;
    logic [XLEN-1:0]        w_fixed;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0]      w_a_ext;
    logic [2*XLEN-1:0]      w_b_ext;
    logic [2*XLEN-1:0]      w_fast_prod;
`endif

    assign in_ready     = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign result_valid = (r_state == DONE);
    assign result       = r_result;
    assign rd_out       = r_rd;
    assign w_accept     = in_valid && in_ready && !flush;

    // Decode the op code into signedness and final result selection
    always_comb begin
        w_is_m     = 1'b0;
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        w_sel      = SEL_LO;
        case (alu_operation)
            ALU_OPERATIONS_MUL:    begin w_is_m = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1; w_sel = SEL_LO;  end
            ALU_OPERATIONS_MULH:   begin w_is_m = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1; w_sel = SEL_HI;  end
            ALU_OPERATIONS_MULHSU: begin w_is_m = 1'b1; w_a_signed = 1'b1;                    w_sel = SEL_HI;  end
            ALU_OPERATIONS_MULHU:  begin w_is_m = 1'b1;                                       w_sel = SEL_HI;  end
            ALU_OPERATIONS_DIV:    begin w_is_m = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1; w_sel = SEL_QUO; end
            ALU_OPERATIONS_DIVU:   begin w_is_m = 1'b1;                                       w_sel = SEL_QUO; end
            ALU_OPERATIONS_REM:    begin w_is_m = 1'b1; w_a_signed = 1'b1; w_b_signed = 1'b1; w_sel = SEL_REM; end
            ALU_OPERATIONS_REMU:   begin w_is_m = 1'b1;                                       w_sel = SEL_REM; end
            default: ;
        endcase
    end

    assign w_is_mul   = w_is_m && ((w_sel == SEL_LO) || (w_sel == SEL_HI));
    assign w_is_div   = w_is_m && ((w_sel == SEL_QUO) || (w_sel == SEL_REM));
    assign w_a_neg    = w_a_signed && operand_a[XLEN-1];
    assign w_b_neg    = w_b_signed && operand_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~operand_a + XLEN'(1)) : operand_a;
    assign w_b_mag    = w_b_neg ? (~operand_b + XLEN'(1)) : operand_b;
    // Remainder takes the dividend's sign; product/quotient negative iff signs differ
    assign w_res_neg  = (w_sel == SEL_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
    assign w_div_zero = w_is_div && (operand_b == '0);
    assign w_overflow = w_is_div && w_a_signed && w_b_signed &&
                        (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);

`ifdef MULDIV_FAST_MUL_EN
    assign w_a_ext     = {{XLEN{w_a_neg}}, operand_a};
    assign w_b_ext     = {{XLEN{w_b_neg}}, operand_b};
    assign w_fast_prod = w_a_ext * w_b_ext;
    assign w_fast      = w_is_mul;
`else
    assign w_fast      = 1'b0;
`endif

    assign w_special = !w_is_m || w_div_zero || w_overflow || w_fast;

    // Result for ops that complete at accept time
    always_comb begin
        w_special_result = '0;
        if (w_div_zero) begin
            w_special_result = (w_sel == SEL_QUO) ? '1 : operand_a;
        end else if (w_overflow) begin
            w_special_result = (w_sel == SEL_QUO) ? operand_a : '0;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (w_fast) begin
            w_special_result = (w_sel == SEL_HI) ? w_fast_prod[2*XLEN-1:XLEN]
                                                 : w_fast_prod[XLEN-1:0];
        end
`endif
    end

    // One shift-add multiply step and one restoring divide step on magnitudes
    assign w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_b : '0)};
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_b};

    assign w_prod_fix = r_neg ? (~{r_hi, r_lo} + (2*XLEN)'(1)) : {r_hi, r_lo};
    assign w_quo_fix  = r_neg ? (~r_lo + XLEN'(1)) : r_lo;
    assign w_rem_fix  = r_neg ? (~r_hi + XLEN'(1)) : r_hi;

    // Sign fixup and half/quotient/remainder selection
    always_comb begin
        w_fixed = '0;
        case (r_sel)
            SEL_LO:  w_fixed = w_prod_fix[XLEN-1:0];
            SEL_HI:  w_fixed = w_prod_fix[2*XLEN-1:XLEN];
            SEL_QUO: w_fixed = w_quo_fix;
            SEL_REM: w_fixed = w_rem_fix;
            default: w_fixed = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state; flush wins over every other transition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid && !flush) w_state_next = w_special ? DONE : CALC;
            CALC:    if (r_counter == LAST_ITER) w_state_next = FIXUP;
            FIXUP:   w_state_next = DONE;
            DONE:    if (result_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (flush) begin
            w_state_next = IDLE;
        end
    end

    // Datapath: latch op at accept, iterate in CALC, fix up into the result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel     <= SEL_LO;
            r_neg     <= 1'b0;
            r_counter <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_rd      <= '0;
        end else if (w_accept) begin
            r_sel     <= w_sel;
            r_neg     <= w_res_neg;
            r_counter <= '0;
            r_rd      <= rd_in;
            r_hi      <= '0;
            r_lo      <= w_is_div ? w_a_mag : w_b_mag;
            r_b       <= w_is_div ? w_b_mag : w_a_mag;
            if (w_special) begin
                r_result <= w_special_result;
            end
        end else if (r_state == CALC && !flush) begin
            r_counter <= r_counter + CW'(1);
            if (r_sel == SEL_QUO || r_sel == SEL_REM) begin
                r_hi <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
            end else begin
                r_hi <= w_sum[XLEN:1];
                r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end
        end else if (r_state == FIXUP && !flush) begin
            r_result <= w_fixed;
        end
    end

endmodule
